// File: rtl/exponential_pkg.sv
// Shared types and constants for the bf16 exponential unit and its requester arbiter.
package exponential_pkg;

    localparam int LAMP_FLOAT_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ADV
    } exp_arb_state_t;

    localparam logic [LAMP_FLOAT_DW-1:0] EXP_ARB_NAN = 16'h7FC0;

    localparam int EXP_ARB_NREQ    = 4;
    localparam int EXP_ARB_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Shares one exponential unit between NREQ requesters: round-robin accept,
// unit handshake sequencing, result routing and a stall watchdog.
//
// state | meaning
// IDLE  | waiting for a request while the unit is ready; grant is combinational
// ISSUE | one-cycle valid pulse to the unit with the latched operand
// WAIT  | waiting for the unit result; watchdog counting
// RESP  | result (or qNaN on timeout) offered to the granted requester
// ADV   | one-cycle padv pulse releasing the unit
module exp_arbiter
    import exponential_pkg::*;
#(
    parameter int NREQ    = EXP_ARB_NREQ,
    parameter int TIMEOUT = EXP_ARB_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid_i,
    input  logic [NREQ*LAMP_FLOAT_DW-1:0] req_data_i,
    output logic [NREQ-1:0]               req_ready_o,
    output logic [NREQ-1:0]               rsp_valid_o,
    output logic [LAMP_FLOAT_DW-1:0]      rsp_data_o,
    output logic                          rsp_err_o,
    input  logic [NREQ-1:0]               rsp_ready_i,
    input  logic                          exp_ready_i,
    output logic                          exp_valid_o,
    output logic [LAMP_FLOAT_DW-1:0]      exp_data_o,
    input  logic                          exp_valid_i,
    input  logic [LAMP_FLOAT_DW-1:0]      exp_data_i,
    output logic                          exp_padv_o,
    output logic                          busy_o
);

    localparam int DW = LAMP_FLOAT_DW;
    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT) + 1;

    exp_arb_state_t state_q, state_d;

    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [WW-1:0]   wdog_q;
    logic [DW-1:0]   op_q;
    logic [DW-1:0]   res_q;
    logic            err_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            arb_en;
    logic            timeout_hit;
    logic [DW-1:0]   sel_data;

    assign arb_en      = (state_q == IDLE) && exp_ready_i;
    assign timeout_hit = (wdog_q == WW'(TIMEOUT - 1));
    assign exp_data_o  = op_q;
    assign busy_o      = (state_q != IDLE);

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (grant),
        .idx   (gidx)
    );

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gidx == IW'(k)) begin
                sel_data = req_data_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        rsp_err_o   = 1'b0;
        exp_valid_o = 1'b0;
        exp_padv_o  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = grant;
                if (|grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                exp_valid_o = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (exp_valid_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = NREQ'(1) << idx_q;
                rsp_data_o  = res_q;
                rsp_err_o   = err_q;
                if (rsp_ready_i[idx_q]) begin
                    state_d = ADV;
                end
            end
            ADV: begin
                exp_padv_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        op_q  <= sel_data;
                        idx_q <= gidx;
                        ptr_q <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
                    end
                end
                ISSUE: wdog_q <= '0;
                WAIT: begin
                    wdog_q <= wdog_q + WW'(1);
                    // A real result arriving on the timeout cycle takes precedence.
                    if (exp_valid_i) begin
                        res_q <= exp_data_i;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_q <= EXP_ARB_NAN;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/exp_arbiter.md
Name: exp_arbiter

Overview:
- Round-robin controller that shares one exponential_top bf16 exponential unit between NREQ requesters.
- Accepts one operand at a time and sequences the unit's handshake: wait ready, pulse valid, wait valid_o, deliver result, pulse padv.
- Routes the result back to the granted requester.
- Includes a watchdog so a stalled unit cannot hang the system.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles in WAIT before an error response is returned (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid_i  in  NREQ  requester operand valid.
- req_data_i  in  NREQ*LAMP_FLOAT_DW  operands; requester k at bits [k*16 +: 16].
- req_ready_o  out  NREQ  one-hot operand accept.
- rsp_valid_o  out  NREQ  one-hot result valid.
- rsp_data_o  out  LAMP_FLOAT_DW  result, shared by all requesters.
- rsp_err_o  out  1  result came from timeout; qualified by rsp_valid_o.
- rsp_ready_i  in  NREQ  requester result accept.
- exp_ready_i  in  1  unit ready_o.
- exp_valid_o  out  1  to unit valid_i.
- exp_data_o  out  LAMP_FLOAT_DW  to unit data_i.
- exp_valid_i  in  1  unit valid_o.
- exp_data_i  in  LAMP_FLOAT_DW  unit data_o.
- exp_padv_o  out  1  to unit padv_i.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, rr pointer=0, wdog=0, data/idx/err regs=0. All outputs 0. rst has priority over every other event, including mid-operation; an in-flight operand is dropped with no response.
- States: IDLE -> ISSUE -> WAIT -> RESP -> ADV -> IDLE.
- IDLE: grant is combinational, rr-first among req_valid_i, gated by exp_ready_i.
  - If any request and exp_ready_i: req_ready_o[g]=1 this cycle; latch operand and idx=g; ptr<=(g+1) mod NREQ; go to ISSUE.
  - If no request or !exp_ready_i: stay, req_ready_o=0.
- ISSUE: exp_valid_o=1 and exp_data_o=latched operand for exactly one cycle; wdog<=0; go to WAIT.
- WAIT: exp_data_o holds the operand; wdog increments each cycle.
  - exp_valid_i: latch exp_data_i, err<=0, go to RESP.
  - Else if wdog==TIMEOUT-1: latch 16'h7FC0 (qNaN), err<=1, go to RESP.
  - If both occur in the same cycle, exp_valid_i wins.
- RESP: rsp_valid_o[idx]=1, rsp_data_o=latched result, rsp_err_o=err; hold until rsp_ready_i[idx]==1, then go to ADV. rsp_ready_i of other requesters is ignored.
- ADV: exp_padv_o=1 for one cycle to release the unit; go to IDLE. The next grant is possible in the following cycle.
- Outputs outside their state are 0, except exp_data_o, which holds the last operand.
- Latency:
  - Accept at cycle T; exp_valid_o at T+1.
  - If the unit responds at T+1+L, rsp_valid_o rises at T+2+L.
  - Minimum accept-to-accept period is L+4 cycles with immediate rsp_ready.
- Fairness: the pointer advances past the granted requester only, so every requester holding valid is served within NREQ grants.
- Requester rule: must hold req_valid_i/req_data_i stable until req_ready_o.
- wdog width: $clog2(TIMEOUT)+1 bits; no wrap.

Decomposition:
- exponential_pkg: add exp_arb_state_t enum (IDLE, ISSUE, WAIT, RESP, ADV), EXP_ARB_NAN = 16'h7FC0, and default constants EXP_ARB_NREQ=4 and EXP_ARB_TIMEOUT=64. Reuse LAMP_FLOAT_DW.
- Sub-module rr_arbiter (parameter N): inputs req, ptr, en; outputs one-hot grant and binary index. Purely combinational; the pointer register lives in exp_arbiter.

Test Plan:
- Single request: req0 sends 16'h0000, model unit L=3 -> exp_valid_o at T+1, rsp_valid_o[0] at T+5 with rsp_data_o=16'h3F80, rsp_err_o=0, exp_padv_o one cycle after rsp_ready_i[0].
- Contention: all 4 requesters valid continuously from reset, operand 16'h3F80 -> grant order 0,1,2,3,0; each rsp_data_o=16'h402E; no requester is starved.
- Backpressure: rsp_ready_i[2] held low 10 cycles -> rsp_valid_o[2] and rsp_data_o are stable for 10 cycles; no exp_padv_o and no new req_ready_o during the stall.
- Timeout: unit never asserts valid_o -> after TIMEOUT cycles in WAIT, rsp_valid_o[idx]=1 with rsp_data_o=16'h7FC0 and rsp_err_o=1, then exp_padv_o pulses.
- Unit not ready: exp_ready_i=0 with req1 valid -> req_ready_o stays 0 and state stays IDLE; exp_ready_i rising -> grant to req1 that cycle.
- Reset mid-WAIT: rst=0 for one cycle -> next cycle all outputs 0, busy_o=0, ptr=0; the dropped request is re-served when rst is released.
